logic_gate_pipe: RTL and testbench

//   Parametrised, registered N-input bitwise logic unit with runtime-selectable

---
 rtl/logic_gate_pipe.sv | 146 ++++++++++++++
 tb/tb_logic_gate_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : logic_gate_pipe                                              |
// | Description : Registered NUM_IN-operand bitwise logic unit. The operation   |
// |               (AND/OR/XOR/NAND/NOR/XNOR) is selected per transaction. Both |
// |               sides use valid/ready handshakes. Results are queued in a    |
// |               2-entry output buffer.                                       |
// | Ports       : clk       - rising-edge clock                                |
// |               rst_n     - asynchronous active-low reset                    |
// |               in_valid  - input transaction present                        |
// |               in_ready  - unit can accept a transaction (occupancy < 2)    |
// |               in_ops    - packed operands, operand i = [i*WIDTH +: WIDTH]  |
// |               in_op     - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,       |
// |                           6/7 illegal                                      |
// |               out_valid - buffer head holds a result                       |
// |               out_ready - downstream accepts the head result               |
// |               out_y     - bitwise result across all operands               |
// |               out_all   - &out_y                                           |
// |               out_any   - |out_y                                           |
// |               out_err   - head result came from an illegal op              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module logic_gate_pipe #(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_ops,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_y,
  output logic                    out_all,
  output logic                    out_any,
  output logic                    out_err
);

  localparam logic [2:0] C_OP_AND  = 3'd0;
  localparam logic [2:0] C_OP_OR   = 3'd1;
  localparam logic [2:0] C_OP_XOR  = 3'd2;
  localparam logic [2:0] C_OP_NAND = 3'd3;
  localparam logic [2:0] C_OP_NOR  = 3'd4;
  localparam logic [2:0] C_OP_XNOR = 3'd5;

  // Entry layout: {err, any, all, y}. The flags are stored alongside y so the
  // head outputs are a pure register read and always agree with each other.
  localparam int ENTRY_W = WIDTH + 3;

  // --------------------------------------------------------------------------
  // Combinational reduction across all operands
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   w_and;
  logic [WIDTH-1:0]   w_or;
  logic [WIDTH-1:0]   w_xor;
  logic [WIDTH-1:0]   w_y;
  logic               w_err;
  logic [ENTRY_W-1:0] w_entry;

  always_comb begin
    w_and = in_ops[WIDTH-1:0];
    w_or  = in_ops[WIDTH-1:0];
    w_xor = in_ops[WIDTH-1:0];
    for (int i = 1; i < NUM_IN; i++) begin
      w_and = w_and & in_ops[i*WIDTH +: WIDTH];
      w_or  = w_or  | in_ops[i*WIDTH +: WIDTH];
      w_xor = w_xor ^ in_ops[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    case (in_op)
      C_OP_AND:  w_y = w_and;
      C_OP_OR:   w_y = w_or;
      C_OP_XOR:  w_y = w_xor;
      C_OP_NAND: w_y = ~w_and;
      C_OP_NOR:  w_y = ~w_or;
      C_OP_XNOR: w_y = ~w_xor;
      // Illegal ops still occupy a slot so the handshake count stays exact;
      // the result is forced to zero and flagged.
      default:   w_err = 1'b1;
    endcase
    w_entry = {w_err, |w_y, &w_y, w_y};
  end

  // --------------------------------------------------------------------------
  // 2-entry output buffer
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               wr_ptr_d;
  logic               rd_ptr_q;
  logic               rd_ptr_d;
  logic [1:0]         cnt_q;
  logic [1:0]         cnt_d;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  // in_ready looks only at the registered count, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ w_push;
    rd_ptr_d = rd_ptr_q ^ w_pop;
    cnt_d    = cnt_q;
    if (w_push && !w_pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!w_push && w_pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_entry;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign w_head  = mem_q[rd_ptr_q];
  assign out_y   = w_head[WIDTH-1:0];
  assign out_all = w_head[WIDTH];
  assign out_any = w_head[WIDTH+1];
  assign out_err = w_head[WIDTH+2];

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_logic_gate_pipe                                           |
// | Description : Directed self-checking bench for logic_gate_pipe. Instance A |
// |               uses default parameters, instance B uses WIDTH=8, NUM_IN=3.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_logic_gate_pipe;

  logic clk;
  logic rst_n;

  // Instance A: WIDTH=1, NUM_IN=2
  logic       a_in_valid;
  logic       a_in_ready;
  logic [1:0] a_in_ops;
  logic [2:0] a_in_op;
  logic       a_out_valid;
  logic       a_out_ready;
  logic [0:0] a_out_y;
  logic       a_out_all;
  logic       a_out_any;
  logic       a_out_err;

  // Instance B: WIDTH=8, NUM_IN=3
  logic        b_in_valid;
  logic        b_in_ready;
  logic [23:0] b_in_ops;
  logic [2:0]  b_in_op;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_y;
  logic        b_out_all;
  logic        b_out_any;
  logic        b_out_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_y_tbl [6];
  logic [1:0] a_vec_tbl [4];
  logic       a_exp_tbl [4];
  logic [7:0] val;

  logic_gate_pipe u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_ops    (a_in_ops),
    .in_op     (a_in_op),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_y     (a_out_y),
    .out_all   (a_out_all),
    .out_any   (a_out_any),
    .out_err   (a_out_err)
  );

  logic_gate_pipe #(
    .WIDTH  (8),
    .NUM_IN (3)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_ops    (b_in_ops),
    .in_op     (b_in_op),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_y     (b_out_y),
    .out_all   (b_out_all),
    .out_any   (b_out_any),
    .out_err   (b_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_y_tbl[0] = 8'h80; exp_y_tbl[1] = 8'hFE; exp_y_tbl[2] = 8'h96;
    exp_y_tbl[3] = 8'h7F; exp_y_tbl[4] = 8'h01; exp_y_tbl[5] = 8'h69;
    a_vec_tbl[0] = 2'b00; a_vec_tbl[1] = 2'b10; a_vec_tbl[2] = 2'b01; a_vec_tbl[3] = 2'b11;
    a_exp_tbl[0] = 1'b0;  a_exp_tbl[1] = 1'b0;  a_exp_tbl[2] = 1'b0;  a_exp_tbl[3] = 1'b1;

    rst_n       = 1'b0;
    a_in_valid  = 1'b0; a_in_ops = '0; a_in_op = 3'd0; a_out_ready = 1'b0;
    b_in_valid  = 1'b0; b_in_ops = '0; b_in_op = 3'd0; b_out_ready = 1'b0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    check("rst_b_out_y",     {24'd0, b_out_y},     32'd0);
    check("rst_b_flags",     {29'd0, b_out_err, b_out_any, b_out_all}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);
    check("rst_b_idle_valid", {31'd0, b_out_valid}, 32'd0);

    // ---------------- Test 1: 2-input AND sweep ----------------
    a_out_ready = 1'b1;
    a_in_op     = 3'd0;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_ops = a_vec_tbl[i];
      tick();
      check($sformatf("t1_valid_%0d", i), {31'd0, a_out_valid}, 32'd1);
      check($sformatf("t1_y_%0d", i),     {31'd0, a_out_y},     {31'd0, a_exp_tbl[i]});
      check($sformatf("t1_err_%0d", i),   {31'd0, a_out_err},   32'd0);
    end
    check("t1_all_last", {31'd0, a_out_all}, 32'd1);
    a_in_valid = 1'b0;
    tick();
    check("t1_drain_valid", {31'd0, a_out_valid}, 32'd0);

    // ---------------- Test 2: 3x8-bit, all legal ops ----------------
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_ops    = {8'hAA, 8'hCC, 8'hF0};
    for (int op = 0; op < 6; op++) begin
      b_in_op = op[2:0];
      tick();
      check($sformatf("t2_valid_op%0d", op), {31'd0, b_out_valid}, 32'd1);
      check($sformatf("t2_y_op%0d", op),     {24'd0, b_out_y},     {24'd0, exp_y_tbl[op]});
      check($sformatf("t2_all_op%0d", op),   {31'd0, b_out_all},   32'd0);
      check($sformatf("t2_any_op%0d", op),   {31'd0, b_out_any},   32'd1);
      check($sformatf("t2_err_op%0d", op),   {31'd0, b_out_err},   32'd0);
    end

    // ---------------- Test 3: illegal ops ----------------
    b_in_ops = 24'hFFFFFF;
    b_in_op  = 3'd6;
    tick();
    check("t3_op6_y",   {24'd0, b_out_y},   32'd0);
    check("t3_op6_err", {31'd0, b_out_err}, 32'd1);
    check("t3_op6_any", {31'd0, b_out_any}, 32'd0);
    check("t3_op6_all", {31'd0, b_out_all}, 32'd0);
    b_in_op = 3'd0;
    tick();
    check("t3_and_y",   {24'd0, b_out_y},   32'h0000_00FF);
    check("t3_and_err", {31'd0, b_out_err}, 32'd0);
    check("t3_and_all", {31'd0, b_out_all}, 32'd1);
    b_in_op = 3'd7;
    tick();
    check("t3_op7_err", {31'd0, b_out_err}, 32'd1);
    check("t3_op7_y",   {24'd0, b_out_y},   32'd0);
    b_in_valid = 1'b0;
    tick();
    check("t3_drain_valid", {31'd0, b_out_valid}, 32'd0);

    // ---------------- Test 4: backpressure ----------------
    // OR of three equal operands reproduces the operand value.
    b_out_ready = 1'b0;
    b_in_op     = 3'd1;
    b_in_valid  = 1'b1;
    b_in_ops    = {3{8'h11}};
    tick();
    check("t4_ready_1", {31'd0, b_in_ready}, 32'd1);
    check("t4_head_1",  {24'd0, b_out_y},    32'h11);
    b_in_ops = {3{8'h22}};
    tick();
    check("t4_ready_full", {31'd0, b_in_ready}, 32'd0);
    check("t4_head_hold",  {24'd0, b_out_y},    32'h11);
    b_in_ops = {3{8'h33}};
    tick();
    check("t4_ready_still_full", {31'd0, b_in_ready}, 32'd0);
    check("t4_head_hold2",       {24'd0, b_out_y},    32'h11);
    b_out_ready = 1'b1;
    tick();
    check("t4_pop_22",    {24'd0, b_out_y},    32'h22);
    check("t4_ready_one", {31'd0, b_in_ready}, 32'd1);
    tick();
    check("t4_pop_33",   {24'd0, b_out_y},     32'h33);
    check("t4_valid_33", {31'd0, b_out_valid}, 32'd1);
    b_in_valid = 1'b0;
    tick();
    check("t4_drain_valid", {31'd0, b_out_valid}, 32'd0);

    // ---------------- Test 5: simultaneous push/pop at occupancy 1 ----------------
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    val         = 8'h05;
    b_in_ops    = {3{val}};
    tick();
    b_out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      val      = 8'(i * 19 + 5);
      b_in_ops = {3{val}};
      tick();
      check($sformatf("t5_y_%0d", i),     {24'd0, b_out_y},     {24'd0, val});
      check($sformatf("t5_occ1_%0d", i),  {30'd0, b_out_valid, b_in_ready}, 32'd3);
    end
    b_in_valid = 1'b0;
    tick();
    check("t5_drain_valid", {31'd0, b_out_valid}, 32'd0);

    // ---------------- Test 6: reset mid-operation ----------------
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_ops    = {3{8'hA5}};
    tick();
    b_in_ops = {3{8'h5A}};
    tick();
    check("t6_full", {31'd0, b_in_ready}, 32'd0);
    b_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, b_out_valid}, 32'd0);
    check("t6_rst_y",     {24'd0, b_out_y},     32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_no_stale_%0d", i), {31'd0, b_out_valid}, 32'd0);
      check($sformatf("t6_ready_%0d", i),    {31'd0, b_in_ready},  32'd1);
    end
    b_in_valid = 1'b1;
    b_in_ops   = {3{8'h3C}};
    tick();
    check("t6_fresh_valid", {31'd0, b_out_valid}, 32'd1);
    check("t6_fresh_y",     {24'd0, b_out_y},     32'h3C);
    b_in_valid = 1'b0;
    tick();
    check("t6_fresh_drain", {31'd0, b_out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
